// File: rtl/byte_striping_c.sv
// Two-lane word striper in the 2f clock domain; lanes alternate by clock phase.
// Optional valid-word counter enabled by BYTE_STRIPE_CNT_EN.
module byte_striping_c #(
  parameter int DATA_W = 32
) (
  input  logic              clk_2f_c,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_1,
  output logic [DATA_W-1:0] lane_1,
  output logic              phase_c
`ifdef BYTE_STRIPE_CNT_EN
  ,
  output logic [15:0]       word_cnt
`endif
);

  logic [DATA_W-1:0] word_q;

  assign word_q = valid_in ? data_in : '0;

  // phase_c resets to 1 so the first edge feeds lane 1
  always_ff @(posedge clk_2f_c or posedge reset) begin
    if (reset) begin
      valid_0 <= 1'b0;
      lane_0  <= '0;
      valid_1 <= 1'b0;
      lane_1  <= '0;
      phase_c <= 1'b1;
    end else begin
      phase_c <= ~phase_c;
      if (phase_c) begin
        valid_1 <= valid_in;
        lane_1  <= word_q;
      end else begin
        valid_0 <= valid_in;
        lane_0  <= word_q;
      end
    end
  end

`ifdef BYTE_STRIPE_CNT_EN
  always_ff @(posedge clk_2f_c or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (valid_in) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_byte_striping_c.sv
// Scoreboard bench for byte_striping_c: slot-history reference model,
// directed cases plus a random stream with bubbles.
module tb_byte_striping_c;

  localparam int W = 32;

  logic          clk_2f_c;
  logic          reset;
  logic          valid_in;
  logic [W-1:0]  data_in;
  logic          valid_0;
  logic [W-1:0]  lane_0;
  logic          valid_1;
  logic [W-1:0]  lane_1;
  logic          phase_c;
`ifdef BYTE_STRIPE_CNT_EN
  logic [15:0]   word_cnt;
`endif

  byte_striping_c #(.DATA_W(W)) dut (
    .clk_2f_c (clk_2f_c),
    .reset    (reset),
    .valid_in (valid_in),
    .data_in  (data_in),
    .valid_0  (valid_0),
    .lane_0   (lane_0),
    .valid_1  (valid_1),
    .lane_1   (lane_1),
    .phase_c  (phase_c)
`ifdef BYTE_STRIPE_CNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  initial begin
    clk_2f_c = 1'b0;
    forever #5 clk_2f_c = ~clk_2f_c;
  end

  typedef struct {
    logic         v0;
    logic [W-1:0] l0;
    logic         v1;
    logic [W-1:0] l1;
    logic         ph;
    logic [15:0]  cnt;
  } exp_t;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
  } slot_t;

  int     errors = 0;
  int     checks = 0;
  exp_t   expq[$];
  slot_t  hist[$];
  int     vcnt = 0;

  // Expected outputs after k edges: slot i feeds lane 1 when i is even,
  // lane 0 when odd; each lane shows its most recent slot.
  function automatic exp_t model();
    exp_t  e;
    int    k;
    int    j;
    k = hist.size();
    e.ph  = (k % 2 == 0);
    e.v0  = 1'b0;
    e.l0  = '0;
    e.v1  = 1'b0;
    e.l1  = '0;
    e.cnt = 16'(vcnt % 65536);
    if (k >= 1) begin
      j = ((k - 1) / 2) * 2;
      e.v1 = hist[j].v;
      e.l1 = hist[j].v ? hist[j].d : '0;
    end
    if (k >= 2) begin
      j = ((k - 1) % 2 == 1) ? k - 1 : k - 2;
      e.v0 = hist[j].v;
      e.l0 = hist[j].v ? hist[j].d : '0;
    end
    return e;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d);
    slot_t s;
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f_c);
    #1;
    s.v = v;
    s.d = d;
    hist.push_back(s);
    if (v) vcnt++;
    expq.push_back(model());
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (valid_0 !== 1'b0 || lane_0 !== '0 || valid_1 !== 1'b0 ||
        lane_1 !== '0 || phase_c !== 1'b1) begin
      errors++;
      $display("FAIL %s: got v0=%b l0=%h v1=%b l1=%h ph=%b, want zeros ph=1",
               nm, valid_0, lane_0, valid_1, lane_1, phase_c);
    end
`ifdef BYTE_STRIPE_CNT_EN
    checks++;
    if (word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s_cnt: got %0d want 0", nm, word_cnt);
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk_2f_c);
    #1;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    #1;
    check_zero("reset_async");
    @(posedge clk_2f_c);
    @(posedge clk_2f_c);
    #1;
    check_zero("reset_held");
    reset = 1'b0;
    hist.delete();
    vcnt = 0;
  endtask

  // Monitor: compare every edge's outputs against the queued expectation.
  always @(negedge clk_2f_c) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (valid_0 !== e.v0 || lane_0 !== e.l0 || valid_1 !== e.v1 ||
          lane_1 !== e.l1 || phase_c !== e.ph) begin
        errors++;
        $display("FAIL lanes slot %0d: got v0=%b l0=%h v1=%b l1=%h ph=%b, want v0=%b l0=%h v1=%b l1=%h ph=%b",
                 hist.size(), valid_0, lane_0, valid_1, lane_1, phase_c,
                 e.v0, e.l0, e.v1, e.l1, e.ph);
      end
`ifdef BYTE_STRIPE_CNT_EN
      checks++;
      if (word_cnt !== e.cnt) begin
        errors++;
        $display("FAIL word_cnt: got %0d want %0d", word_cnt, e.cnt);
      end
`endif
    end
  end

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    #2;
    check_zero("reset_init");
    @(posedge clk_2f_c);
    #1;
    reset = 1'b0;

    // A1..A4 back to back
    step(1'b1, 32'hA1);
    step(1'b1, 32'hA2);
    step(1'b1, 32'hA3);
    step(1'b1, 32'hA4);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

    // A1, bubble, A3
    do_reset();
    step(1'b1, 32'hA1);
    step(1'b0, 32'hFFFF);
    step(1'b1, 32'hA3);
    step(1'b1, 32'hA4);

    // Mid-stream async reset while lane_0 holds DEADBEEF
    do_reset();
    step(1'b1, 32'h1234_5678);
    step(1'b1, 32'hDEAD_BEEF);
    do_reset();
    step(1'b1, 32'hCAFE_0001);
    step(1'b1, 32'hCAFE_0002);

    // Random stream, ~20% bubbles
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(99) >= 20, W'($urandom));
    end

`ifdef BYTE_STRIPE_CNT_EN
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      step(1'b1, W'($urandom));
    end
    @(negedge clk_2f_c);
    #1;
    checks++;
    if (word_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d want 1", word_cnt);
    end
`endif

    @(negedge clk_2f_c);
    @(negedge clk_2f_c);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
